// File: rtl/pid_pkg.sv
// Shared definitions for the incremental PI controller.
//   DATA_W : width of the target, the gains, the bounds and pi_out
//   ADC_W  : width of the raw ADC sample
//   ERR_W  : signed error width. It holds target minus the zero-extended sample.
//   PROD_W : signed increment width. It is wide enough for kp*(de) + ki*e without overflow.
//   SUM_W  : signed accumulate width, used for pi_out plus the limited step.
// saturate() clamps a signed accumulate result into [lo, hi].
package pid_pkg;

  localparam int DATA_W = 26;
  localparam int ADC_W  = 12;
  localparam int ERR_W  = 27;
  localparam int PROD_W = 56;
  localparam int SUM_W  = DATA_W + 2;

  function automatic logic [DATA_W-1:0] saturate(
    input logic signed [SUM_W-1:0]  v,
    input logic        [DATA_W-1:0] lo,
    input logic        [DATA_W-1:0] hi
  );
    if (v < $signed({2'b00, lo})) begin
      return lo;
    end else if (v > $signed({2'b00, hi})) begin
      return hi;
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/pid_limit.sv
// Combinational block that turns a raw increment into a clamped next output.
//   delta    : signed raw increment, kp*(e - e_prev) + ki*e
//   cur_out  : current controller output
//   next_out : output after the limited step and the saturation clamp
// A zero increment stays zero. A nonzero increment is forced into the range
// [minimum_add, maximum_add] in magnitude and keeps the sign of delta.
module pid_limit
  import pid_pkg::*;
#(
  parameter logic [DATA_W-1:0] maximum_out = 26'd1000,
  parameter logic [DATA_W-1:0] minimum_out = 26'd0,
  parameter logic [DATA_W-1:0] maximum_add = 26'd100,
  parameter logic [DATA_W-1:0] minimum_add = 26'd10
) (
  input  logic signed [PROD_W-1:0] delta,
  input  logic        [DATA_W-1:0] cur_out,
  output logic        [DATA_W-1:0] next_out
);

  logic        [PROD_W-1:0] mag;
  logic        [DATA_W-1:0] step_mag;
  logic signed [SUM_W-1:0]  step;
  logic signed [SUM_W-1:0]  sum;

  always_comb begin
    mag      = delta[PROD_W-1] ? -delta : delta;
    step_mag = '0;
    if (mag == '0) begin
      step_mag = '0;
    end else if (mag > {{(PROD_W-DATA_W){1'b0}}, maximum_add}) begin
      step_mag = maximum_add;
    end else if (mag < {{(PROD_W-DATA_W){1'b0}}, minimum_add}) begin
      step_mag = minimum_add;
    end else begin
      // mag is at most maximum_add here, so it fits in DATA_W bits.
      step_mag = mag[DATA_W-1:0];
    end
    step     = delta[PROD_W-1] ? -$signed({2'b00, step_mag}) : $signed({2'b00, step_mag});
    sum      = $signed({2'b00, cur_out}) + step;
    next_out = saturate(sum, minimum_out, maximum_out);
  end

endmodule

// File: rtl/pid.sv
// Incremental (velocity-form) PI controller that runs on ADC completion events.
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   adc_complete : conversion-done strobe; only its rising edge is used
//   sample       : unsigned ADC result
//   target       : unsigned setpoint
//   pi_out       : registered, saturated control output
// Pipeline stages:
//   Stage 1 (event edge): latch the error and shift the old error into e_prev.
//   Stage 2: form the gain-weighted increment.
//   Stage 3: limit the step and accumulate it into pi_out.
module pid
  import pid_pkg::*;
#(
  parameter logic [DATA_W-1:0] kp          = 26'd100,
  parameter logic [DATA_W-1:0] ki          = 26'd100,
  parameter logic [DATA_W-1:0] maximum_out = 26'd1000,
  parameter logic [DATA_W-1:0] minimum_out = 26'd0,
  parameter logic [DATA_W-1:0] maximum_add = 26'd100,
  parameter logic [DATA_W-1:0] minimum_add = 26'd10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adc_complete,
  input  logic [ADC_W-1:0]  sample,
  input  logic [DATA_W-1:0] target,
  output logic [DATA_W-1:0] pi_out
);

  logic                     adc_q;
  logic                     adc_event;
  logic                     s1_valid;
  logic                     s2_valid;
  logic signed [ERR_W-1:0]  e;
  logic signed [ERR_W-1:0]  e_prev;
  logic signed [ERR_W-1:0]  e_new;
  logic signed [PROD_W-1:0] delta;
  logic signed [PROD_W-1:0] delta_new;
  logic signed [ERR_W:0]    e_diff;
  logic signed [PROD_W-1:0] kp_ext;
  logic signed [PROD_W-1:0] ki_ext;
  logic signed [PROD_W-1:0] diff_ext;
  logic signed [PROD_W-1:0] e_ext;
  logic        [DATA_W-1:0] next_out;

  assign adc_event = adc_complete & ~adc_q;
  assign e_new     = $signed({1'b0, target}) - $signed({{(ERR_W-ADC_W){1'b0}}, sample});

  // The gains are unsigned, so they are zero-extended. The error terms are
  // sign-extended. The products are then taken at the full increment width.
  always_comb begin
    e_diff    = {e[ERR_W-1], e} - {e_prev[ERR_W-1], e_prev};
    kp_ext    = {{(PROD_W-DATA_W){1'b0}}, kp};
    ki_ext    = {{(PROD_W-DATA_W){1'b0}}, ki};
    diff_ext  = {{(PROD_W-ERR_W-1){e_diff[ERR_W]}}, e_diff};
    e_ext     = {{(PROD_W-ERR_W){e[ERR_W-1]}}, e};
    delta_new = kp_ext * diff_ext + ki_ext * e_ext;
  end

  pid_limit #(
    .maximum_out (maximum_out),
    .minimum_out (minimum_out),
    .maximum_add (maximum_add),
    .minimum_add (minimum_add)
  ) u_limit (
    .delta    (delta),
    .cur_out  (pi_out),
    .next_out (next_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_q    <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      e        <= '0;
      e_prev   <= '0;
      delta    <= '0;
      pi_out   <= minimum_out;
    end else begin
      adc_q    <= adc_complete;
      s1_valid <= adc_event;
      s2_valid <= s1_valid;
      if (adc_event) begin
        e      <= e_new;
        e_prev <= e;
      end
      if (s1_valid) begin
        delta <= delta_new;
      end
      if (s2_valid) begin
        pi_out <= next_out;
      end
    end
  end

endmodule

// File: tb/tb_pid.sv
module tb_pid;

  localparam int N = 3;

  // Configurations: default, small-gain (kp=0, ki=1), and one with non-trivial bounds.
  localparam longint KP  [N] = '{100, 0, 3};
  localparam longint KI  [N] = '{100, 1, 2};
  localparam longint MAXO[N] = '{1000, 1000, 700};
  localparam longint MINO[N] = '{0, 0, 50};
  localparam longint MAXA[N] = '{100, 100, 37};
  localparam longint MINA[N] = '{10, 10, 5};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_complete = 1'b0;
  logic [11:0] sample = '0;
  logic [25:0] target = '0;
  logic [25:0] dut_out [N];

  always #5 clk = ~clk;

  pid u_dut0 (
    .clk(clk), .rst_n(rst_n), .adc_complete(adc_complete),
    .sample(sample), .target(target), .pi_out(dut_out[0])
  );

  pid #(.kp(26'd0), .ki(26'd1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .adc_complete(adc_complete),
    .sample(sample), .target(target), .pi_out(dut_out[1])
  );

  pid #(.kp(26'd3), .ki(26'd2), .maximum_out(26'd700), .minimum_out(26'd50),
        .maximum_add(26'd37), .minimum_add(26'd5)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .adc_complete(adc_complete),
    .sample(sample), .target(target), .pi_out(dut_out[2])
  );

  int vectors = 0;
  int miscompares = 0;
  longint cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Reference model state: the value after every event applied so far, the
  // last error per instance, and a schedule of when each value becomes visible.
  longint m_pi  [N];
  longint m_e   [N];
  longint exp_v [N];

  typedef struct {
    longint due;
    int     idx;
    longint val;
  } sched_t;
  sched_t sched[$];

  task automatic check(input string name, input longint act, input longint expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  function automatic longint model_next(input int i, input longint delta, input longint cur);
    longint mag, step, s;
    mag = (delta < 0) ? -delta : delta;
    if (delta == 0)          step = 0;
    else if (mag > MAXA[i])  step = MAXA[i];
    else if (mag < MINA[i])  step = MINA[i];
    else                     step = mag;
    if (delta < 0) step = -step;
    s = cur + step;
    if (s > MAXO[i]) s = MAXO[i];
    if (s < MINO[i]) s = MINO[i];
    return s;
  endfunction

  task automatic model_event(input longint tgt, input longint smp, input longint due);
    longint e, delta;
    for (int i = 0; i < N; i++) begin
      e       = tgt - smp;
      delta   = KP[i] * (e - m_e[i]) + KI[i] * e;
      m_e[i]  = e;
      m_pi[i] = model_next(i, delta, m_pi[i]);
      sched.push_back('{due: due, idx: i, val: m_pi[i]});
    end
  endtask

  task automatic model_reset();
    sched.delete();
    for (int i = 0; i < N; i++) begin
      m_pi[i]  = MINO[i];
      m_e[i]   = 0;
      exp_v[i] = MINO[i];
    end
  endtask

  // Check every instance against the model on each falling edge.
  always @(negedge clk) begin
    while (sched.size() > 0 && sched[0].due <= cyc) begin
      exp_v[sched[0].idx] = sched[0].val;
      void'(sched.pop_front());
    end
    for (int i = 0; i < N; i++) check($sformatf("pi_out[%0d]", i), longint'(dut_out[i]), exp_v[i]);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Raise the strobe for hi cycles, then drop it for lo cycles (lo >= 2, so the
  // update is visible on return). Inputs are scrambled after the event edge.
  task automatic pulse(input longint tgt, input longint smp, input int hi, input int lo);
    target = tgt[25:0];
    sample = smp[11:0];
    adc_complete = 1'b1;
    model_event(tgt, smp, cyc + 3);
    for (int k = 0; k < hi; k++) begin
      tick();
      target = 26'($urandom);
      sample = 12'($urandom);
    end
    adc_complete = 1'b0;
    for (int k = 0; k < lo; k++) tick();
  endtask

  task automatic do_reset();
    adc_complete = 1'b0;
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t, s;
    model_reset();
    tick();
    tick();
    check("reset_out0", longint'(dut_out[0]), 0);
    check("reset_out2", longint'(dut_out[2]), 50);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("idle_out0", longint'(dut_out[0]), 0);

    // Ramp to saturation with defaults: +100 per event, holding at 1000.
    for (int k = 1; k <= 12; k++) begin
      pulse(300, 290, 1, 9);
      check($sformatf("ramp_ev%0d", k), longint'(dut_out[0]), (k >= 10) ? 1000 : 100 * k);
    end

    // Small error on the kp=0, ki=1 instance: the minimum step of 10 applies.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      pulse(300, 299, 1, 2);
      check($sformatf("small_ev%0d", k), longint'(dut_out[1]), 10 * k);
    end
    pulse(300, 300, 1, 2);
    check("zero_err", longint'(dut_out[1]), 30);

    // Preload to 500, then drive a large negative error down to the floor.
    do_reset();
    for (int k = 0; k < 5; k++) pulse(300, 290, 1, 2);
    check("preload", longint'(dut_out[0]), 500);
    for (int k = 1; k <= 7; k++) begin
      pulse(300, 4095, 1, 2);
      check($sformatf("neg_ev%0d", k), longint'(dut_out[0]), (k >= 5) ? 0 : 500 - 100 * k);
    end

    // A strobe held high for 20 cycles produces exactly one update.
    do_reset();
    pulse(300, 290, 20, 4);
    check("held_strobe", longint'(dut_out[0]), 100);

    // Reset one cycle after an event: the in-flight increment is dropped.
    do_reset();
    target = 26'd300;
    sample = 12'd290;
    adc_complete = 1'b1;
    model_event(300, 290, cyc + 3);
    tick();
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    check("mid_reset", longint'(dut_out[0]), 0);

    // Random events, with occasional resets.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 24) == 0) do_reset();
      s = longint'($urandom_range(0, 4095));
      case ($urandom_range(0, 3))
        0:       t = s;
        1:       t = s + longint'($urandom_range(0, 40)) - 20;
        2:       t = longint'($urandom_range(0, 5000));
        default: t = longint'($urandom & 32'h03FF_FFFF);
      endcase
      if (t < 0) t = 0;
      pulse(t, s, $urandom_range(1, 4), $urandom_range(2, 4));
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pid.md
# pid

Incremental (velocity-form) PI controller for the power-stage control loop. On each ADC conversion-complete event it takes the fresh 12-bit sample and computes the error against a 26-bit target. It forms a gain-weighted increment, limits that increment's magnitude, and accumulates it into a saturated 26-bit control output. It sits between the ADC interface and the PWM/duty-cycle generator.

## Interface
Parameters (all 26-bit unsigned):
- kp, 26'd100: proportional gain, applied to the error difference.
- ki, 26'd100: integral gain, applied to the current error.
- maximum_out, 26'd1000: upper saturation bound of pi_out.
- minimum_out, 26'd0: lower saturation bound of pi_out, and the reset value of pi_out.
- maximum_add, 26'd100: maximum magnitude of one increment.
- minimum_add, 26'd10: minimum magnitude of a nonzero increment.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- adc_complete  in  1  conversion-done strobe; only its rising edge is used.
- sample  in  12  ADC result, unsigned, zero-extended internally.
- target  in  26  setpoint, unsigned.
- pi_out  out  26  control output, unsigned, registered.

## Operation
- Edge detect:
  - adc_complete is registered into adc_q.
  - event = adc_complete & ~adc_q.
  - A strobe held high produces exactly one event.
- Stage 1, on the event edge:
  - e <= target − {14'b0, sample}, signed 27-bit.
  - e_prev <= old e.
- Stage 2, one cycle later: delta <= kp·(e − e_prev) + ki·e. Signed, at least 56 bits, so no overflow is possible.
- Stage 3, one cycle later, step rule:
  - If delta == 0, step = 0.
  - Else if |delta| > maximum_add, step = ±maximum_add.
  - Else if |delta| < minimum_add, step = ±minimum_add.
  - Else step = delta.
  - The sign of step follows delta.
- Accumulate: sum = pi_out + step in signed 28-bit, then clamp to [minimum_out, maximum_out] and write to pi_out.
- No scaling or shift is applied; gains are integer.
- Parameter legality: minimum_out ≤ maximum_out and minimum_add ≤ maximum_add. Behaviour for other values is undefined.

## Timing
- Reset values:
  - pi_out = minimum_out.
  - e, e_prev, delta = 0.
  - adc_q = 0.
  - Pipeline valid flags = 0.
- Latency: an event detected at clock edge N updates pi_out at edge N+2.
- pi_out changes only on a stage-3 valid cycle and is otherwise held.
- Throughput:
  - Events are at least 2 cycles apart, because the strobe must go low then high again.
  - The pipeline accepts every event; no event is dropped.
  - Each accumulate uses the current pi_out.
- sample and target are sampled only on the event edge. Changes at other times have no effect until the next event.
- The first event after reset uses e_prev = 0.
- Reset asserted mid-pipeline clears everything, including in-flight increments.
- Saturation: the result stays at maximum_out or minimum_out while the error persists, with no wrap-around. Because the controller is velocity-form, there is no integrator wind-up.

## Structure
- Shared package holds:
  - width constants: DATA_W=26, ADC_W=12, ERR_W=27, PROD_W=56;
  - a saturate/clamp function.
- Natural sub-module: pid_limit, a combinational block for the step-magnitude limit and output clamp.
- Edge detector and pipeline registers stay in pid.

## Test plan
- Reset: rst_n=0 → pi_out=0 (minimum_out). Release with no strobe → pi_out stays 0.
- Target 300, sample 290, defaults, strobe every 110 ns:
  - 1st event: delta = 2000 → step 100 → pi_out=100 two cycles after the edge.
  - Following events: delta = 1000 → step 100 → 200, 300, …
  - Saturates at 1000 after the 10th event and holds.
- Small error, target 300, sample 299, kp=0, ki=1: delta=1 → step=minimum_add → pi_out +10 per event. With sample=300, delta=0 → pi_out unchanged.
- Negative error: pi_out preloaded to 500 via prior events, then sample=4095 with target 300 → step −100 per event, clamped at 0, no underflow wrap.
- Strobe held high for 20 cycles → exactly one update.
- Assert rst_n low one cycle after an event → no late update; pi_out=minimum_out.
